// File: rtl/dcache_controller_if.sv
// CPU load/store and block-memory signals of the data cache, bundled for port connection.
// slave = cache view; master = environment view (CPU driver plus memory model).
interface dcache_controller_if;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache, 8 x 4-byte lines (optional stats: DCACHE_STATS_EN).
// Latency: hits complete in the request cycle; clean miss N+1, dirty miss 2N+1 stall cycles.
// Backpressure: BUSYWAIT stalls the CPU on a miss; MEM_BUSYWAIT low for one cycle ends each memory phase.
module dcache_controller #(
    parameter int NUM_BLOCKS = 8,
    parameter int TAG_W      = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    dcache_controller_if.slave  bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]         HIT_COUNT,
    output logic [15:0]         MISS_COUNT
`endif
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t                  state_q, state_d;
    logic [NUM_BLOCKS-1:0]   valid_q, valid_d;
    logic [NUM_BLOCKS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]        tag_q  [NUM_BLOCKS];
    logic [TAG_W-1:0]        tag_d  [NUM_BLOCKS];
    logic [31:0]             data_q [NUM_BLOCKS];
    logic [31:0]             data_d [NUM_BLOCKS];
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [5:0]              mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;

    logic [2:0]              idx;
    logic [1:0]              off;
    logic [TAG_W-1:0]        req_tag;
    logic                    req;
    logic                    hit;

    assign idx     = bus.ADDRESS[4:2];
    assign off     = bus.ADDRESS[1:0];
    assign req_tag = bus.ADDRESS[7:5];
    assign req     = bus.READ | bus.WRITE;
    assign hit     = valid_q[idx] & (tag_q[idx] == req_tag);

    assign bus.READDATA      = data_q[idx][{off, 3'b000} +: 8];
    assign bus.BUSYWAIT      = req & ~((state_q == IDLE) & hit);
    assign bus.MEM_READ      = mem_read_q;
    assign bus.MEM_WRITE     = mem_write_q;
    assign bus.MEM_ADDRESS   = mem_addr_q;
    assign bus.MEM_WRITEDATA = mem_wdata_q;

    // Memory strobes/address are registered alongside the state so they change only at state changes.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        case (state_q)
            IDLE: begin
                if (req & hit & bus.WRITE) begin
                    data_d[idx][{off, 3'b000} +: 8] = bus.WRITEDATA;
                    dirty_d[idx]                    = 1'b1;
                end else if (req & ~hit & dirty_q[idx]) begin
                    state_d     = WRITEBACK;
                    mem_write_d = 1'b1;
                    mem_addr_d  = {tag_q[idx], idx};
                    mem_wdata_d = data_q[idx];
                end else if (req & ~hit) begin
                    state_d    = REFILL;
                    mem_read_d = 1'b1;
                    mem_addr_d = {req_tag, idx};
                end
            end
            WRITEBACK: begin
                if (!bus.MEM_BUSYWAIT) begin
                    state_d    = REFILL;
                    mem_read_d = 1'b1;
                    mem_addr_d = {req_tag, idx};
                end else begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            REFILL: begin
                if (!bus.MEM_BUSYWAIT) begin
                    state_d      = IDLE;
                    data_d[idx]  = bus.MEM_READDATA;
                    tag_d[idx]   = req_tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                end else begin
                    mem_read_d = 1'b1;
                    mem_addr_d = mem_addr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            tag_q       <= '{default: '0};
            data_q      <= '{default: '0};
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        retry_q, retry_d;

    // retry_q marks the post-refill re-evaluation so it is not counted as a hit.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        retry_d    = retry_q;
        if ((state_q == IDLE) && req) begin
            if (hit) begin
                if (!retry_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
                retry_d = 1'b0;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                retry_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            retry_q    <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            retry_q    <= retry_d;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif
endmodule
